instr_mem_loadable: RTL and testbench

- Parametrised, byte-addressed instruction memory for the MIPS fetch stage, with registered (1-cycle) synchronous read.
- Adds several features:
  - configurable depth and byte order;
  - a fetch request/stall handshake;
  - alignment and range error detection;
  - a byte-serial program-load port, so a bench or boot loader can fill memory at run time.
- Sits between the PC register and the decode stage.

---
 rtl/instr_mem_loadable.sv | 148 ++++++++++++++
 tb/tb_instr_mem_loadable.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Byte-addressed instruction memory for the MIPS fetch stage.
// Registered 1-cycle read, fetch request/stall handshake, alignment and
// range error detection, and a byte-serial program-load port.
module instr_mem_loadable #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_req,
  input  logic [31:0]                   fetch_addr,
  input  logic                          fetch_stall,
  output logic [31:0]                   instruction,
  output logic                          instr_valid,
  output logic                          fetch_err,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [7:0]                    load_byte,
  input  logic                          load_last,
  output logic                          load_busy,
  output logic                          load_done,
  output logic                          load_ovf,
  output logic [$clog2(DEPTH_BYTES):0]  load_count
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam int unsigned CW        = AW + 1;
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);
  localparam logic [CW-1:0] PTR_FULL = CW'(DEPTH_BYTES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_load_ptr;
  logic          r_load_busy;
  logic          r_load_done;
  logic          r_load_ovf;
  logic [31:0]   r_instruction;
  logic          r_instr_valid;
  logic          r_fetch_err;
  logic [7:0]    r_mem [DEPTH_BYTES];

  logic          w_ptr_full;
  logic          w_wr_en;
  logic          w_addr_ok;
  logic          w_accept;
  logic [AW-1:0] w_base;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [7:0]    w_b3;
  logic [31:0]   w_word;

  // The pointer doubles as the byte count; it saturates at DEPTH_BYTES.
  assign w_ptr_full = (r_load_ptr == PTR_FULL);
  assign w_wr_en    = (r_state == S_LOAD) & ~load_start & load_valid & ~w_ptr_full;

  // Full 32-bit compare so high addresses never wrap into the array.
  assign w_addr_ok  = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= LAST_WORD);
  assign w_accept   = (r_state == S_IDLE) & fetch_req & ~fetch_stall & ~load_start;

  // Bad addresses are steered to word 0 so no index ever leaves the array.
  assign w_base = w_addr_ok ? fetch_addr[AW-1:0] : '0;
  assign w_b0   = r_mem[w_base];
  assign w_b1   = r_mem[w_base + AW'(1)];
  assign w_b2   = r_mem[w_base + AW'(2)];
  assign w_b3   = r_mem[w_base + AW'(3)];
  assign w_word = BIG_ENDIAN ? {w_b0, w_b1, w_b2, w_b3} : {w_b3, w_b2, w_b1, w_b0};

  // Byte-wide storage; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_load_ptr[AW-1:0]] <= load_byte;
    end
  end

  // Load state machine: pointer, overflow flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_load_ptr  <= '0;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
      r_load_ovf  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state     <= S_LOAD;
            r_load_busy <= 1'b1;
            r_load_ptr  <= '0;
            r_load_ovf  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_start) begin
            r_load_ptr <= '0;
            r_load_ovf <= 1'b0;
          end else if (load_valid) begin
            if (w_ptr_full) begin
              r_load_ovf <= 1'b1;
            end else begin
              r_load_ptr <= r_load_ptr + CW'(1);
            end
            if (load_last) begin
              r_state     <= S_IDLE;
              r_load_busy <= 1'b0;
              r_load_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Fetch output register: stall holds, accept updates, otherwise drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else if (fetch_stall) begin
      r_instruction <= r_instruction;
      r_instr_valid <= r_instr_valid;
      r_fetch_err   <= r_fetch_err;
    end else if (w_accept) begin
      r_instruction <= w_addr_ok ? w_word : NOP_WORD;
      r_instr_valid <= 1'b1;
      r_fetch_err   <= ~w_addr_ok;
    end else begin
      r_instr_valid <= 1'b0;
    end
  end

  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign fetch_err   = r_fetch_err;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;
  assign load_ovf    = r_load_ovf;
  assign load_count  = r_load_ptr;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: three instances (256B big-endian,
// 256B little-endian with a distinct NOP word, 8B big-endian) share stimulus.
module tb_instr_mem_loadable;

  localparam logic [31:0] LE_NOP = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;

  logic [31:0] be_instr, le_instr, sm_instr;
  logic        be_valid, le_valid, sm_valid;
  logic        be_err, le_err, sm_err;
  logic        be_busy, le_busy, sm_busy;
  logic        be_done, le_done, sm_done;
  logic        be_ovf, le_ovf, sm_ovf;
  logic [8:0]  be_count, le_count;
  logic [3:0]  sm_count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       tag;
    int          inst;
    logic [31:0] instr;
    bit          ci;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];

  instr_mem_loadable #(.DEPTH_BYTES(256), .BIG_ENDIAN(1'b1), .NOP_WORD(32'h0000_0000)) u_be (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instruction(be_instr), .instr_valid(be_valid),
    .fetch_err(be_err), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_busy(be_busy),
    .load_done(be_done), .load_ovf(be_ovf), .load_count(be_count));

  instr_mem_loadable #(.DEPTH_BYTES(256), .BIG_ENDIAN(1'b0), .NOP_WORD(LE_NOP)) u_le (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instruction(le_instr), .instr_valid(le_valid),
    .fetch_err(le_err), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_busy(le_busy),
    .load_done(le_done), .load_ovf(le_ovf), .load_count(le_count));

  instr_mem_loadable #(.DEPTH_BYTES(8), .BIG_ENDIAN(1'b1), .NOP_WORD(32'h0000_0000)) u_sm (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instruction(sm_instr), .instr_valid(sm_valid),
    .fetch_err(sm_err), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_busy(sm_busy),
    .load_done(sm_done), .load_ovf(sm_ovf), .load_count(sm_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point used by every check.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int inst, input logic [31:0] instr,
                      input bit ci, input logic valid, input logic err);
    exp_t e;
    e.tag = tag; e.inst = inst; e.instr = instr; e.ci = ci; e.valid = valid; e.err = err;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare against the matching instance.
  task automatic drain();
    exp_t        e;
    logic [31:0] oi;
    logic        ov, oe;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0:       begin oi = be_instr; ov = be_valid; oe = be_err; end
        1:       begin oi = le_instr; ov = le_valid; oe = le_err; end
        default: begin oi = sm_instr; ov = sm_valid; oe = sm_err; end
      endcase
      if (e.ci) chk({e.tag, ".instr"}, oi, e.instr);
      chk({e.tag, ".valid"}, 32'(ov), 32'(e.valid));
      chk({e.tag, ".err"}, 32'(oe), 32'(e.err));
    end
  endtask

  task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_byte  = bytes[i];
      load_last  = (i == 3);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_byte = '0; load_last = 1'b0;

    // Reset values
    #12;
    chk("rst.instr", be_instr, 32'h0);
    chk("rst.valid", 32'(be_valid), 32'h0);
    chk("rst.err",   32'(be_err), 32'h0);
    chk("rst.busy",  32'(be_busy), 32'h0);
    chk("rst.done",  32'(be_done), 32'h0);
    chk("rst.ovf",   32'(sm_ovf), 32'h0);
    chk("rst.count", 32'(be_count), 32'h0);
    rst_n = 1'b1;

    // Overflow: 10 bytes into the 8-byte instance
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ovf.busy",  32'(be_busy), 32'h1);
    chk("ovf.count0", 32'(be_count), 32'h0);
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'(8'hA0 + i);
      load_last  = (i == 9);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("ovf.sm_count", 32'(sm_count), 32'd8);
    chk("ovf.sm_ovf",   32'(sm_ovf), 32'h1);
    chk("ovf.sm_done",  32'(sm_done), 32'h1);
    chk("ovf.be_count", 32'(be_count), 32'd10);
    chk("ovf.be_ovf",   32'(be_ovf), 32'h0);
    chk("ovf.be_busy",  32'(be_busy), 32'h0);
    fetch_req = 1'b1; fetch_addr = 32'd4;
    push("ovf.rd4.be", 0, 32'hA4A5A6A7, 1'b1, 1'b1, 1'b0);
    push("ovf.rd4.le", 1, 32'hA7A6A5A4, 1'b1, 1'b1, 1'b0);
    push("ovf.rd4.sm", 2, 32'hA4A5A6A7, 1'b1, 1'b1, 1'b0);
    tick(); drain();
    chk("ovf.done_clr", 32'(sm_done), 32'h0);
    fetch_addr = 32'd8;
    push("ovf.rd8.be", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    push("ovf.rd8.sm", 2, 32'h0, 1'b1, 1'b1, 1'b1);
    tick(); drain();
    fetch_req = 1'b0;

    // New load clears overflow, then load 01 4B 48 20
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ld.sm_ovf_clr",   32'(sm_ovf), 32'h0);
    chk("ld.sm_count_clr", 32'(sm_count), 32'h0);
    chk("ld.sm_busy",      32'(sm_busy), 32'h1);
    load_bytes(8'h01, 8'h4B, 8'h48, 8'h20);
    chk("ld.done",  32'(be_done), 32'h1);
    chk("ld.count", 32'(be_count), 32'd4);
    chk("ld.busy",  32'(be_busy), 32'h0);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    push("ld.rd0.be", 0, 32'h014B4820, 1'b1, 1'b1, 1'b0);
    push("ld.rd0.le", 1, 32'h20484B01, 1'b1, 1'b1, 1'b0);
    push("ld.rd0.sm", 2, 32'h014B4820, 1'b1, 1'b1, 1'b0);
    tick(); drain();
    chk("ld.done_pulse", 32'(be_done), 32'h0);

    // Address errors and range boundary
    fetch_addr = 32'd252;
    push("err.252.be", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    push("err.252.sm", 2, 32'h0, 1'b1, 1'b1, 1'b1);
    tick(); drain();
    fetch_addr = 32'd2;
    push("err.2.be", 0, 32'h0, 1'b1, 1'b1, 1'b1);
    push("err.2.le", 1, LE_NOP, 1'b1, 1'b1, 1'b1);
    tick(); drain();
    fetch_req = 1'b0;
    push("idle.be", 0, 32'h0, 1'b1, 1'b0, 1'b1);
    push("idle.le", 1, LE_NOP, 1'b1, 1'b0, 1'b1);
    tick(); drain();
    fetch_req = 1'b1; fetch_addr = 32'd254;
    push("err.254.be", 0, 32'h0, 1'b1, 1'b1, 1'b1);
    tick(); drain();
    fetch_addr = 32'hFFFF_FFFC;
    push("err.wrap.be", 0, 32'h0, 1'b1, 1'b1, 1'b1);
    push("err.wrap.le", 1, LE_NOP, 1'b1, 1'b1, 1'b1);
    tick(); drain();

    // Stall holds output for three cycles
    fetch_addr = 32'd0;
    push("stl.rd0.be", 0, 32'h014B4820, 1'b1, 1'b1, 1'b0);
    tick(); drain();
    fetch_stall = 1'b1; fetch_addr = 32'd4;
    for (int i = 0; i < 3; i++) begin
      push("stl.hold.be", 0, 32'h014B4820, 1'b1, 1'b1, 1'b0);
      push("stl.hold.le", 1, 32'h20484B01, 1'b1, 1'b1, 1'b0);
      tick(); drain();
    end
    fetch_stall = 1'b0;
    push("stl.rel.be", 0, 32'hA4A5A6A7, 1'b1, 1'b1, 1'b0);
    push("stl.rel.le", 1, 32'hA7A6A5A4, 1'b1, 1'b1, 1'b0);
    tick(); drain();

    // Load/fetch conflict, then fetch during LOAD
    fetch_addr = 32'd0; load_start = 1'b1;
    push("cf.start.be", 0, 32'hA4A5A6A7, 1'b1, 1'b0, 1'b0);
    tick(); drain();
    chk("cf.busy", 32'(be_busy), 32'h1);
    load_start = 1'b0; load_valid = 1'b1; load_byte = 8'h11;
    push("cf.ld1.be", 0, 32'hA4A5A6A7, 1'b1, 1'b0, 1'b0);
    tick(); drain();
    chk("cf.count1", 32'(be_count), 32'd1);
    load_byte = 8'h22;
    push("cf.ld2.be", 0, 32'hA4A5A6A7, 1'b1, 1'b0, 1'b0);
    tick(); drain();
    chk("cf.count2", 32'(be_count), 32'd2);
    load_valid = 1'b0; fetch_req = 1'b0;

    // Asynchronous reset mid-load
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.instr", be_instr, 32'h0);
    chk("mrst.valid", 32'(be_valid), 32'h0);
    chk("mrst.busy",  32'(be_busy), 32'h0);
    chk("mrst.count", 32'(be_count), 32'h0);
    chk("mrst.done",  32'(be_done), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mrst.no_done", 32'(be_done), 32'h0);
    chk("mrst.idle",    32'(be_busy), 32'h0);

    // load_valid in IDLE is ignored
    load_valid = 1'b1; load_byte = 8'hFF;
    tick();
    load_valid = 1'b0;
    chk("idlev.count", 32'(be_count), 32'h0);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    push("mrst.rd0.be", 0, 32'h11224820, 1'b1, 1'b1, 1'b0);
    push("mrst.rd0.le", 1, 32'h20482211, 1'b1, 1'b1, 1'b0);
    push("mrst.rd0.sm", 2, 32'h11224820, 1'b1, 1'b1, 1'b0);
    tick(); drain();
    fetch_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
